// File: rtl/instr_loader.sv
// Serial instruction loader: assembles received bytes into words for the instruction memory
// and sequences CPU reset, run and single-step control from one-byte commands.
module instr_loader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 64,
  parameter int unsigned RST_CYCLES = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [BYTE_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_valid,
  input  logic                  i_finish,
  output logic [DATA_WIDTH-1:0] o_instruccion,
  output logic [DATA_WIDTH-1:0] o_address,
  output logic                  o_loading,
  output logic                  o_cpu_reset,
  output logic                  o_start,
  output logic                  o_step,
  output logic                  o_error
);

  localparam int unsigned BytesPerWord = DATA_WIDTH / BYTE_WIDTH;
  localparam int unsigned ByteCntW     = (BytesPerWord > 1) ? $clog2(BytesPerWord) : 1;
  localparam int unsigned WordCntW     = $clog2(MEM_DEPTH + 1);
  localparam int unsigned RstCntW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned AsmW         = DATA_WIDTH - BYTE_WIDTH;

  localparam logic [BYTE_WIDTH-1:0] CmdLoad = BYTE_WIDTH'(8'h4C);
  localparam logic [BYTE_WIDTH-1:0] CmdRun  = BYTE_WIDTH'(8'h52);
  localparam logic [BYTE_WIDTH-1:0] CmdStep = BYTE_WIDTH'(8'h53);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFlush,
    StCpuRst,
    StRun,
    StStep
  } state_e;

  state_e                state_q;
  logic [AsmW-1:0]       asm_q;
  logic [ByteCntW-1:0]   byte_cnt_q;
  logic [WordCntW-1:0]   word_cnt_q;
  logic [RstCntW-1:0]    rst_cnt_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic [DATA_WIDTH-1:0] address_q;
  logic                  loading_q;
  logic                  cpu_reset_q;
  logic                  start_q;
  logic                  step_q;
  logic                  error_q;

  logic [DATA_WIDTH-1:0] word_asm;
  logic                  last_byte;
  logic                  is_halt;

  // asm_q holds only the earlier bytes of the word; the current byte completes it.
  assign word_asm  = {asm_q, i_rx_data};
  assign last_byte = (byte_cnt_q == ByteCntW'(BytesPerWord - 1));
  assign is_halt   = &word_asm[DATA_WIDTH-1 -: 6];

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= StIdle;
      asm_q       <= '0;
      byte_cnt_q  <= '0;
      word_cnt_q  <= '0;
      rst_cnt_q   <= '0;
      instr_q     <= '0;
      address_q   <= '0;
      loading_q   <= 1'b0;
      cpu_reset_q <= 1'b0;
      start_q     <= 1'b0;
      step_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (i_rx_valid) begin
            if (i_rx_data == CmdLoad) begin
              state_q    <= StLoad;
              loading_q  <= 1'b1;
              address_q  <= '0;
              error_q    <= 1'b0;
              byte_cnt_q <= '0;
              word_cnt_q <= '0;
            end else if (i_rx_data == CmdRun) begin
              state_q <= StRun;
              start_q <= 1'b1;
              step_q  <= 1'b1;
            end else if (i_rx_data == CmdStep) begin
              state_q <= StStep;
              start_q <= 1'b1;
              step_q  <= 1'b1;
            end
          end
        end
        StLoad: begin
          // The last permitted word has already been presented for one write cycle.
          if (word_cnt_q == WordCntW'(MEM_DEPTH)) begin
            state_q   <= StIdle;
            loading_q <= 1'b0;
            error_q   <= 1'b1;
          end else if (i_rx_valid) begin
            asm_q      <= word_asm[AsmW-1:0];
            byte_cnt_q <= byte_cnt_q + ByteCntW'(1);
            if (last_byte) begin
              byte_cnt_q <= '0;
              instr_q    <= word_asm;
              address_q  <= DATA_WIDTH'(word_cnt_q);
              word_cnt_q <= word_cnt_q + WordCntW'(1);
              if (is_halt) begin
                state_q <= StFlush;
              end
            end
          end
        end
        StFlush: begin
          state_q     <= StCpuRst;
          cpu_reset_q <= 1'b1;
          rst_cnt_q   <= '0;
        end
        StCpuRst: begin
          if (rst_cnt_q == RstCntW'(RST_CYCLES - 1)) begin
            state_q     <= StIdle;
            cpu_reset_q <= 1'b0;
            loading_q   <= 1'b0;
          end else begin
            rst_cnt_q <= rst_cnt_q + RstCntW'(1);
          end
        end
        StRun: begin
          if (i_finish) begin
            state_q <= StIdle;
            start_q <= 1'b0;
            step_q  <= 1'b0;
          end
        end
        StStep: begin
          step_q <= 1'b0;
          if (i_finish) begin
            state_q <= StIdle;
            start_q <= 1'b0;
          end else if (i_rx_valid && (i_rx_data == CmdStep)) begin
            step_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_instruccion = instr_q;
  assign o_address     = address_q;
  assign o_loading     = loading_q;
  assign o_cpu_reset   = cpu_reset_q;
  assign o_start       = start_q;
  assign o_step        = step_q;
  assign o_error       = error_q;

endmodule

// File: tb/tb_instr_loader.sv
// Randomized self-checking bench for instr_loader; expected load outcomes come from a
// word-list model (writes up to the first HALT, capped at the memory depth).
module tb_instr_loader;

  localparam int unsigned DW    = 32;
  localparam int unsigned BW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned RSTC  = 2;

  logic          i_clock = 1'b0;
  logic          i_reset;
  logic [BW-1:0] i_rx_data;
  logic          i_rx_valid;
  logic          i_finish;
  logic [DW-1:0] o_instruccion;
  logic [DW-1:0] o_address;
  logic          o_loading;
  logic          o_cpu_reset;
  logic          o_start;
  logic          o_step;
  logic          o_error;

  instr_loader #(
    .DATA_WIDTH(DW),
    .BYTE_WIDTH(BW),
    .MEM_DEPTH (DEPTH),
    .RST_CYCLES(RSTC)
  ) u_dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .i_finish     (i_finish),
    .o_instruccion(o_instruccion),
    .o_address    (o_address),
    .o_loading    (o_loading),
    .o_cpu_reset  (o_cpu_reset),
    .o_start      (o_start),
    .o_step       (o_step),
    .o_error      (o_error)
  );

  always #5 i_clock = ~i_clock;

  int unsigned   n_checks = 0;
  int unsigned   n_fail   = 0;
  logic [31:0]   wq[$];
  int unsigned   gap_lo;
  int unsigned   gap_hi;
  logic [31:0]   last_instr;
  bit            err_exp;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge i_clock) begin
    if (i_reset) check_eq("load_start_excl", 32'(o_loading & o_start), 0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic send_byte(input logic [BW-1:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
    i_rx_data  = '0;
  endtask

  function automatic bit is_halt_w(input logic [31:0] w);
    return w[31:26] == 6'h3F;
  endfunction

  function automatic logic [31:0] rand_word(input bit halt);
    logic [31:0] w;
    w = $urandom;
    if (halt) w[31:26] = 6'h3F;
    else if (w[31:26] == 6'h3F) w[26] = 1'b0;
    return w;
  endfunction

  // Words written for the list in wq, and whether the load ends in overflow.
  function automatic int model_writes(output bit ovf);
    ovf = 1'b0;
    for (int i = 0; i < wq.size(); i++) begin
      if (is_halt_w(wq[i])) return i + 1;
      if (i + 1 == int'(DEPTH)) begin
        ovf = 1'b1;
        return int'(DEPTH);
      end
    end
    return wq.size();
  endfunction

  task automatic do_load();
    int          n;
    int          g;
    int          hold_addr;
    bit          ovf;
    logic [31:0] w;
    logic [7:0]  junk;
    n = model_writes(ovf);
    send_byte(8'h4C);
    check_eq("L_loading", 32'(o_loading), 1);
    check_eq("L_addr0", o_address, 0);
    check_eq("L_err_clr", 32'(o_error), 0);
    hold_addr = 0;
    for (int i = 0; i < n; i++) begin
      w = wq[i];
      for (int j = 0; j < 4; j++) begin
        g = int'($urandom_range(gap_hi, gap_lo));
        repeat (g) begin
          tick();
          check_eq("gap_addr", o_address, hold_addr);
          check_eq("gap_instr", o_instruccion, last_instr);
        end
        send_byte(w[31-8*j -: 8]);
        if (j < 3) begin
          check_eq("partial_addr", o_address, hold_addr);
          check_eq("partial_instr", o_instruccion, last_instr);
        end
      end
      check_eq("wr_instr", o_instruccion, w);
      check_eq("wr_addr", o_address, i);
      check_eq("wr_loading", 32'(o_loading), 1);
      check_eq("wr_err", 32'(o_error), 0);
      last_instr = w;
      hold_addr  = i;
    end
    err_exp = ovf;
    if (ovf) begin
      tick();
      check_eq("ovf_err", 32'(o_error), 1);
      check_eq("ovf_loading", 32'(o_loading), 0);
      check_eq("ovf_cpurst", 32'(o_cpu_reset), 0);
    end else if (n > 0 && is_halt_w(wq[n-1])) begin
      check_eq("flush_loading", 32'(o_loading), 1);
      check_eq("flush_cpurst", 32'(o_cpu_reset), 0);
      junk = 8'($urandom);
      send_byte(junk);
      check_eq("cpurst_hi", 32'(o_cpu_reset), 1);
      check_eq("cpurst_loading", 32'(o_loading), 1);
      check_eq("cpurst_instr_hold", o_instruccion, last_instr);
      for (int k = 1; k < int'(RSTC); k++) begin
        tick();
        check_eq("cpurst_hold", 32'(o_cpu_reset), 1);
        check_eq("cpurst_hold_loading", 32'(o_loading), 1);
      end
      tick();
      check_eq("cpurst_end", 32'(o_cpu_reset), 0);
      check_eq("cpurst_end_loading", 32'(o_loading), 0);
      check_eq("cpurst_end_start", 32'(o_start), 0);
    end
  endtask

  task automatic run_test(input int cycles);
    send_byte(8'h52);
    check_eq("run_start", 32'(o_start), 1);
    check_eq("run_step", 32'(o_step), 1);
    for (int c = 1; c < cycles; c++) begin
      if ($urandom_range(0, 2) == 0) send_byte(8'($urandom));
      else tick();
      check_eq("run_hold_start", 32'(o_start), 1);
      check_eq("run_hold_step", 32'(o_step), 1);
      check_eq("run_loading", 32'(o_loading), 0);
    end
    i_finish = 1'b1;
    tick();
    i_finish = 1'b0;
    check_eq("run_end_start", 32'(o_start), 0);
    check_eq("run_end_step", 32'(o_step), 0);
    check_eq("run_err_sticky", 32'(o_error), 32'(err_exp));
  endtask

  task automatic step_test(input int n);
    int         g;
    logic [7:0] other;
    send_byte(8'h53);
    check_eq("step0_start", 32'(o_start), 1);
    check_eq("step0_step", 32'(o_step), 1);
    tick();
    check_eq("step0_fall", 32'(o_step), 0);
    for (int i = 0; i < n; i++) begin
      g = int'($urandom_range(3, 0));
      repeat (g) begin
        if ($urandom_range(0, 1) == 0) begin
          other = ($urandom_range(0, 1) == 0) ? 8'h52 : 8'h4C;
          send_byte(other);
        end else begin
          tick();
        end
        check_eq("step_idle", 32'(o_step), 0);
        check_eq("step_idle_start", 32'(o_start), 1);
      end
      send_byte(8'h53);
      check_eq("step_pulse", 32'(o_step), 1);
      check_eq("step_pulse_start", 32'(o_start), 1);
      tick();
      check_eq("step_pulse_end", 32'(o_step), 0);
    end
    i_finish = 1'b1;
    send_byte(8'h53);
    i_finish = 1'b0;
    check_eq("step_fin_step", 32'(o_step), 0);
    check_eq("step_fin_start", 32'(o_start), 0);
    send_byte(8'h00);
    check_eq("step_idle_after", 32'(o_start), 0);
  endtask

  task automatic reset_mid_load();
    logic [31:0] w0;
    logic [31:0] w1;
    w0 = rand_word(1'b0);
    w1 = rand_word(1'b0);
    send_byte(8'h4C);
    for (int j = 0; j < 4; j++) send_byte(w0[31-8*j -: 8]);
    check_eq("rml_w0", o_instruccion, w0);
    for (int j = 0; j < 2; j++) send_byte(w1[31-8*j -: 8]);
    #2;
    i_reset = 1'b0;
    #1;
    check_eq("rml_instr", o_instruccion, 0);
    check_eq("rml_addr", o_address, 0);
    check_eq("rml_loading", 32'(o_loading), 0);
    check_eq("rml_cpurst", 32'(o_cpu_reset), 0);
    check_eq("rml_start", 32'(o_start), 0);
    check_eq("rml_step", 32'(o_step), 0);
    check_eq("rml_err", 32'(o_error), 0);
    @(posedge i_clock);
    #1;
    i_reset    = 1'b1;
    last_instr = '0;
    err_exp    = 1'b0;
    tick();
    send_byte(8'h00);
    send_byte(8'h11);
    check_eq("rml_no_write_instr", o_instruccion, 0);
    check_eq("rml_no_write_load", 32'(o_loading), 0);
    wq = '{};
    wq.push_back(rand_word(1'b0));
    wq.push_back(rand_word(1'b1));
    gap_lo = 0;
    gap_hi = 1;
    do_load();
  endtask

  initial begin
    i_reset    = 1'b0;
    i_rx_data  = '0;
    i_rx_valid = 1'b0;
    i_finish   = 1'b0;
    last_instr = '0;
    err_exp    = 1'b0;
    repeat (2) @(posedge i_clock);
    #1;
    check_eq("rst_instr", o_instruccion, 0);
    check_eq("rst_addr", o_address, 0);
    check_eq("rst_loading", 32'(o_loading), 0);
    check_eq("rst_cpurst", 32'(o_cpu_reset), 0);
    check_eq("rst_start", 32'(o_start), 0);
    check_eq("rst_step", 32'(o_step), 0);
    check_eq("rst_err", 32'(o_error), 0);
    i_reset = 1'b1;
    tick();

    wq = '{32'hAC410008, 32'h20430005, 32'hFC000000};
    gap_lo = 0;
    gap_hi = 0;
    do_load();

    wq = '{32'hAC410008, 32'hFC000000};
    gap_lo = 5;
    gap_hi = 5;
    do_load();

    wq = '{};
    for (int i = 0; i < int'(DEPTH); i++) wq.push_back(rand_word(1'b0));
    gap_lo = 0;
    gap_hi = 2;
    do_load();
    run_test(10);
    wq = '{};
    wq.push_back(rand_word(1'b1));
    do_load();

    run_test(20);
    step_test(3);
    reset_mid_load();

    for (int r = 0; r < 8; r++) begin
      wq = '{};
      for (int i = 0; i < int'(DEPTH); i++) wq.push_back(rand_word($urandom_range(0, 2) == 0));
      gap_lo = 0;
      gap_hi = 3;
      do_load();
      if ($urandom_range(0, 1) == 0) run_test(int'($urandom_range(30, 2)));
      else step_test(int'($urandom_range(5, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
